// File: rtl/divider_unit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/ready handshake.
// A zero divisor completes in IDLE on the accepting edge with all-ones quotient and remainder = dividend.
module divider_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             div_zero,
  output logic             busy,
  output logic             ready
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd, dvs, quo, rem;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_d, dvs_d, quo_d, rem_d, q_d, r_d;
  logic [CW-1:0]    cnt_d;
  logic             dz_d, busy_d, ready_d;

  // Remainder stays below the divisor, so WIDTH bits hold it; the trial value needs one more.
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  assign r_sh     = {rem, dvd[WIDTH-1]};
  assign ge       = r_sh >= {1'b0, dvs};
  assign rem_step = ge ? WIDTH'(r_sh - {1'b0, dvs}) : r_sh[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && b_in != '0) state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dvd_d   = dvd;
    dvs_d   = dvs;
    quo_d   = quo;
    rem_d   = rem;
    cnt_d   = cnt;
    q_d     = q_out;
    r_d     = r_out;
    dz_d    = div_zero;
    ready_d = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (b_in != '0) begin
            dvd_d = a_in;
            dvs_d = b_in;
            quo_d = '0;
            rem_d = '0;
            cnt_d = CW'(WIDTH-1);
            dz_d  = 1'b0;
          end else begin
            q_d     = '1;
            r_d     = a_in;
            dz_d    = 1'b1;
            ready_d = 1'b1;
          end
        end
      end
      CALC: begin
        dvd_d = dvd << 1;
        quo_d = {quo[WIDTH-2:0], ge};
        rem_d = rem_step;
        cnt_d = cnt - 1'b1;
        if (cnt == '0) begin
          q_d     = {quo[WIDTH-2:0], ge};
          r_d     = rem_step;
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_nxt == CALC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd      <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      q_out    <= '0;
      r_out    <= '0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b0;
    end else begin
      dvd      <= dvd_d;
      dvs      <= dvs_d;
      quo      <= quo_d;
      rem      <= rem_d;
      cnt      <= cnt_d;
      q_out    <= q_d;
      r_out    <= r_d;
      div_zero <= dz_d;
      busy     <= busy_d;
      ready    <= ready_d;
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Directed and random self-checking bench for divider_unit (WIDTH = 16).
module tb_divider_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic [W-1:0] q_out, r_out;
  logic         div_zero, busy, ready;

  int n_chk = 0;
  int n_err = 0;

  divider_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .q_out(q_out), .r_out(r_out), .div_zero(div_zero), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; the request is taken on the next rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
  endtask

  // lat = rising edges after the accepting edge before ready is seen (0 for divide-by-zero).
  task automatic wait_ready(output int lat, output int bsy);
    lat = 0;
    bsy = 0;
    @(negedge clk);
    start = 1'b0;
    while (!ready && lat < 40) begin
      bsy += int'(busy);
      @(negedge clk);
      lat++;
    end
    bsy += int'(busy);
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                     input int elat, input int ebsy);
    int lat, bsy;
    @(negedge clk);
    start_op(a, b);
    wait_ready(lat, bsy);
    chk({tag, "_q"}, q_out, eq);
    chk({tag, "_r"}, r_out, er);
    chk({tag, "_dz"}, div_zero, edz);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy"}, bsy, ebsy);
    @(negedge clk);
    chk({tag, "_pulse"}, ready, 0);
  endtask

  initial begin
    int lat, bsy, rcnt, rfirst;
    logic [W-1:0] a, b, eq, er;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_q", q_out, 0);
    chk("rst_r", r_out, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);

    run("d100_7", 100, 7, 14, 2, 0, 16, 16);
    run("d3_10", 3, 10, 0, 3, 0, 16, 16);
    run("dffff_1", 16'hFFFF, 1, 16'hFFFF, 0, 0, 16, 16);
    run("d5_0", 5, 0, 16'hFFFF, 5, 1, 0, 0);
    run("d9_3", 9, 3, 3, 0, 0, 16, 16);

    // Second start while busy is dropped; operand inputs change mid-operation.
    @(negedge clk);
    start_op(1000, 9);
    rcnt = 0;
    rfirst = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (ready) begin
        rcnt++;
        if (rfirst < 0) begin
          rfirst = n;
          eq = q_out;
          er = r_out;
        end
      end
      if (n == 4) start_op(8, 2);
      if (n == 5) begin
        start = 1'b0;
        a_in = 77;
        b_in = 5;
      end
    end
    chk("bi_count", rcnt, 1);
    chk("bi_lat", rfirst, 16);
    chk("bi_q", eq, 111);
    chk("bi_r", er, 1);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    start_op(500, 3);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_q", q_out, 0);
    chk("mrst_r", r_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rcnt = 0;
    repeat (20) begin
      @(negedge clk);
      rcnt += int'(ready);
    end
    chk("mrst_noready", rcnt, 0);
    run("d500_3", 500, 3, 166, 2, 0, 16, 16);

    // Back-to-back: each new request is raised in the ready cycle of the previous one.
    @(negedge clk);
    start_op(0, 1);
    wait_ready(lat, bsy);
    for (int i = 0; i < 1000; i++) begin
      case (i % 10)
        0: a = '0;
        1: a = '1;
        default: a = W'($urandom);
      endcase
      case (i % 13)
        0: b = '1;
        1: b = 1;
        5: b = '0;
        default: b = W'($urandom);
      endcase
      eq = (b == '0) ? '1 : a / b;
      er = (b == '0) ? a : a % b;
      start_op(a, b);
      wait_ready(lat, bsy);
      chk("rnd_q", q_out, eq);
      chk("rnd_r", r_out, er);
      chk("rnd_gap", lat + 1, (b == '0) ? 1 : 17);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
